// File: rtl/window_accum_pkg.sv
// window_accum_pkg
// Shared constants for the window accumulator slice:
//   - FSM state encoding (IDLE / WAIT / ACCUM, 2 bits)
//   - default widths for data, delay counter and period/iteration counters
package window_accum_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;

  // Default widths; the delay width tracks the Delay unit's amount width
  localparam int WA_DATA_W  = 32;
  localparam int WA_DELAY_W = 6;
  localparam int WA_CNT_W   = 10;

endpackage

// File: rtl/window_accum_load_down_counter.sv
// load_down_counter
// Loadable down-counter with a zero flag. A load takes priority over a
// decrement; decrementing stops at zero (no wrap).
// Ports:
//   clk_i      in  clock, rising edge
//   rst_ni     in  asynchronous active-low reset
//   load_i     in  load load_val_i into the counter
//   load_val_i in  W-bit load value
//   en_i       in  decrement enable
//   zero_o     out counter is zero
module load_down_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Counter register: load, decrement or hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/window_accum.sv
// window_accum
// Reduces the Delay unit's output stream: after a run pulse, waits `delay`
// cycles, then sums `period` consecutive samples of in0 per window for
// `iterations` back-to-back windows. Each window sum is registered on out0
// with a one-cycle out_valid strobe; a one-cycle done pulse ends the job.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-low reset
//   run        in  start pulse, only honoured in IDLE
//   in0        in  DATA_W sample stream
//   delay      in  DELAY_W cycles to wait before the first sample
//   period     in  CNT_W samples per window
//   iterations in  CNT_W number of windows
//   out0       out DATA_W last completed window sum (held)
//   out_valid  out out0 updated this cycle
//   busy       out job in progress
//   done       out job finished this cycle
module window_accum
  import window_accum_pkg::*;
#(
  parameter int DATA_W  = WA_DATA_W,
  parameter int DELAY_W = WA_DELAY_W,
  parameter int CNT_W   = WA_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic [DELAY_W-1:0] delay,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  iterations,
  output logic [DATA_W-1:0] out0,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [DATA_W-1:0] out0_q, out0_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0]  sum_s;
  logic               d_load_s, d_en_s, d_zero_s;
  logic [DELAY_W-1:0] d_val_s;
  logic               p_load_s, p_en_s, p_zero_s;
  logic [CNT_W-1:0]   p_val_s;
  logic               i_load_s, i_en_s, i_zero_s;
  logic [CNT_W-1:0]   i_val_s;

  // Counters hold "remaining minus one", so the zero flag marks the last
  // WAIT cycle, the last sample of a window and the last window.
  load_down_counter #(.W(DELAY_W)) u_delay_cnt (
    .clk_i(clk), .rst_ni(rst), .load_i(d_load_s), .load_val_i(d_val_s),
    .en_i(d_en_s), .zero_o(d_zero_s)
  );

  load_down_counter #(.W(CNT_W)) u_period_cnt (
    .clk_i(clk), .rst_ni(rst), .load_i(p_load_s), .load_val_i(p_val_s),
    .en_i(p_en_s), .zero_o(p_zero_s)
  );

  load_down_counter #(.W(CNT_W)) u_iter_cnt (
    .clk_i(clk), .rst_ni(rst), .load_i(i_load_s), .load_val_i(i_val_s),
    .en_i(i_en_s), .zero_o(i_zero_s)
  );

  // Next-state, accumulator and counter control
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    first_d     = first_q;
    per_d       = per_q;
    out0_d      = out0_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    d_load_s    = 1'b0;
    d_val_s     = '0;
    d_en_s      = 1'b0;
    p_load_s    = 1'b0;
    p_val_s     = per_q;
    p_en_s      = 1'b0;
    i_load_s    = 1'b0;
    i_val_s     = '0;
    i_en_s      = 1'b0;
    // First sample of a window loads rather than adds
    sum_s       = first_q ? in0 : (acc_q + in0);

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          if ((period == '0) || (iterations == '0)) begin
            done_d = 1'b1;
          end else begin
            per_d    = period - CNT_W'(1);
            p_load_s = 1'b1;
            p_val_s  = period - CNT_W'(1);
            i_load_s = 1'b1;
            i_val_s  = iterations - CNT_W'(1);
            first_d  = 1'b1;
            if (delay == '0) begin
              state_d = ST_ACCUM;
            end else begin
              d_load_s = 1'b1;
              d_val_s  = delay - DELAY_W'(1);
              state_d  = ST_WAIT;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (d_zero_s) begin
          state_d = ST_ACCUM;
        end else begin
          d_en_s = 1'b1;
        end
      end
      ST_ACCUM: begin
        acc_d = sum_s;
        if (p_zero_s) begin
          out0_d      = sum_s;
          out_valid_d = 1'b1;
          first_d     = 1'b1;
          if (i_zero_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            // Next window starts on the very next cycle
            p_load_s = 1'b1;
            i_en_s   = 1'b1;
          end
        end else begin
          p_en_s  = 1'b1;
          first_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      first_q     <= 1'b0;
      per_q       <= '0;
      out0_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      per_q       <= per_d;
      out0_q      <= out0_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out0      = out0_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_window_accum.sv
// tb_window_accum
// Bench for window_accum: tasks drive jobs cycle by cycle and push expected
// window sums / done cycles to queues; a negedge monitor pops and compares.
module tb_window_accum;

  localparam int DATA_W  = 32;
  localparam int DELAY_W = 6;
  localparam int CNT_W   = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic [DATA_W-1:0] in0 = '0;
  logic [DELAY_W-1:0] delay = '0;
  logic [CNT_W-1:0]  period = '0;
  logic [CNT_W-1:0]  iterations = '0;
  logic [DATA_W-1:0] out0;
  logic              out_valid;
  logic              busy;
  logic              done;

  window_accum #(.DATA_W(DATA_W), .DELAY_W(DELAY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .in0(in0), .delay(delay),
    .period(period), .iterations(iterations), .out0(out0),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] last_out = '0;

  typedef struct {
    logic [DATA_W-1:0] sum;
    int                at;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  // Scoreboard monitor: window sums and done pulses with their cycles
  always @(negedge clk) begin
    exp_t e;
    int   dc;
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: cycle %0d out0=%h, none required", cyc, out0);
      end else begin
        e = exp_q.pop_front();
        last_out = e.sum;
        if ((out0 !== e.sum) || (cyc != e.at)) begin
          errors++;
          $display("FAIL window_sum: got %h at cycle %0d, required %h at cycle %0d",
                   out0, cyc, e.sum, e.at);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: cycle %0d, none required", cyc);
      end else begin
        dc = done_q.pop_front();
        if (cyc != dc) begin
          errors++;
          $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, dc);
        end
      end
    end
  end

  // Drive one job starting next cycle; model expected sums from the timing rules
  task automatic run_job(input int d, input int p, input int n, input int mode, input bit disturb);
    int t0;
    int idx;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] acc;
    @(posedge clk); #1;
    t0 = cyc;
    run = 1'b1;
    delay = DELAY_W'(d);
    period = CNT_W'(p);
    iterations = CNT_W'(n);
    in0 = DATA_W'($urandom);
    if ((p == 0) || (n == 0)) done_q.push_back(t0 + 1);
    else done_q.push_back(t0 + d + n * p + 1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_cycle0: got %b, required 0", busy);
    end
    acc = '0;
    if ((p != 0) && (n != 0)) begin
      for (int c = 1; c <= d + n * p; c++) begin
        @(posedge clk); #1;
        case (mode)
          1: v = DATA_W'(c);
          2: v = (c == 1) ? 32'hFFFF_FFFF : 32'h0000_0002;
          default: v = DATA_W'($urandom);
        endcase
        in0 = v;
        if (disturb) begin
          run = 1'($urandom_range(0, 1));
          delay = DELAY_W'($urandom);
          period = CNT_W'($urandom);
          iterations = CNT_W'($urandom);
        end else begin
          run = 1'b0;
        end
        if (c > d) begin
          idx = c - d - 1;
          if ((idx % p) == 0) acc = v;
          else acc = acc + v;
          if ((idx % p) == (p - 1)) exp_q.push_back('{acc, t0 + c + 1});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_job: cycle %0d got %b, required 1", c, busy);
        end
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      run = 1'b0;
      in0 = DATA_W'($urandom);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_idle: got %b, required 0", busy);
      end
    end
  endtask

  task automatic check_out0(input logic [DATA_W-1:0] req, input string name);
    checks++;
    if (out0 !== req) begin
      errors++;
      $display("FAIL %s: out0 got %h, required %h", name, out0, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({out0, out_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_values: got out0=%h ov=%b busy=%b done=%b, required all 0",
               out0, out_valid, busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    run_job(0, 4, 1, 1, 1'b0);
    idle(2);
    check_out0(32'd10, "basic_sum");
  endtask

  task automatic test_delay_align();
    run_job(3, 2, 3, 1, 1'b0);
    idle(2);
    check_out0(32'd17, "delay_last_sum");
  endtask

  task automatic test_overflow();
    run_job(0, 2, 1, 2, 1'b0);
    idle(2);
    check_out0(32'h0000_0001, "overflow_sum");
  endtask

  task automatic test_degenerate();
    run_job(2, 0, 5, 0, 1'b0);
    idle(2);
    check_out0(32'h0000_0001, "degenerate_p0_hold");
    run_job(0, 3, 0, 0, 1'b0);
    idle(2);
    check_out0(32'h0000_0001, "degenerate_n0_hold");
  endtask

  task automatic test_ignored_inputs();
    run_job(2, 3, 2, 0, 1'b1);
    idle(2);
    check_out0(last_out, "ignored_inputs_hold");
  endtask

  task automatic test_reset_midjob();
    int t0;
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] acc;
    @(posedge clk); #1;
    t0 = cyc;
    run = 1'b1;
    delay = DELAY_W'(1);
    period = CNT_W'(3);
    iterations = CNT_W'(3);
    acc = '0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      run = 1'b0;
      v = DATA_W'($urandom);
      in0 = v;
      if (c == 2) acc = v;
      else if ((c == 3) || (c == 4)) acc = acc + v;
      if (c == 4) exp_q.push_back('{acc, t0 + 5});
    end
    // Cycle 6 sits in window 1; reset lands mid-window
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({out0, out_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_midjob: got out0=%h ov=%b busy=%b done=%b, required all 0",
               out0, out_valid, busy, done);
    end
    last_out = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(4);
    check_out0('0, "reset_midjob_out0");
    run_job(0, 2, 2, 0, 1'b0);
    idle(2);
    check_out0(last_out, "after_reset_job");
  endtask

  task automatic test_back_to_back();
    run_job(1, 3, 2, 0, 1'b0);
    run_job(2, 2, 2, 0, 1'b0);
    run_job(0, 1, 3, 0, 1'b0);
    idle(3);
    check_out0(last_out, "back_to_back_last");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_align();
    test_overflow();
    test_degenerate();
    test_ignored_inputs();
    test_reset_midjob();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_sums: %0d outstanding, required 0", exp_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL pending_done: %0d outstanding, required 0", done_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_accum.md
# window_accum

Versatile functional unit that sits directly downstream of the Delay unit and reduces its output stream. After a `run` pulse it waits a programmable number of cycles, so that data routed through Delay stages has arrived, then sums `period` consecutive samples of `in0` per window for `iterations` back-to-back windows. Each window sum is registered on `out0` with a one-cycle `out_valid` strobe. A final `done` pulse ends the job.

## Interface
- `DATA_W`, 32: sample and accumulator width.
- `DELAY_W`, 6: width of `delay`; matches the Delay unit's amount width.
- `CNT_W`, 10: width of `period` and `iterations`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted at 0).
- `run`  in  1  start pulse; sampled only in IDLE.
- `in0`  in  DATA_W  sample stream, from Delay `out0`.
- `delay`  in  DELAY_W  cycles to wait after `run` before the first sample.
- `period`  in  CNT_W  samples per window.
- `iterations`  in  CNT_W  number of windows.
- `out0`  out  DATA_W  last completed window sum, registered and held.
- `out_valid`  out  1  one-cycle strobe, `out0` updated this cycle.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle strobe, job finished.

## Operation
- States: IDLE, WAIT, ACCUM.
- IDLE with `run`=1: latch `delay`, `period` and `iterations` into shadow registers.
  - If `period`=0 or `iterations`=0, stay IDLE and pulse `done` next cycle. `out0` is unchanged and there is no `out_valid`.
  - Else if `delay`=0, go to ACCUM.
  - Otherwise go to WAIT.
- WAIT: count down the latched delay. On the last WAIT cycle, go to ACCUM.
- ACCUM: each cycle samples `in0`.
  - The first sample of a window loads the accumulator (acc ← `in0`). Later samples do acc ← acc + `in0`.
  - There is no bubble between windows.
  - After the `period`-th sample: `out0` ← final sum and `out_valid`=1.
  - If windows remain, continue ACCUM with a fresh window. Otherwise go to IDLE and pulse `done`.
- Arithmetic is modulo 2^DATA_W. Wrap-around is silent. Results are identical for signed and unsigned interpretation.
- `run` while `busy` is ignored. Config input changes while `busy` are ignored (shadowed).
- Reset asserted at any time, including mid-job: state returns to IDLE and all counters clear. `out0`=0, `out_valid`=0, `busy`=0, `done`=0. No `done` is produced for the aborted job.

## Timing
- The cycle in which `run` is seen high in IDLE is cycle 0, with delay D, period P and iterations N.
- `busy` is high in cycles 1 … D+N·P.
- Window k (0-based) samples `in0` in cycles D+k·P+1 … D+(k+1)·P.
- `out0` and `out_valid` for window k are visible in cycle D+(k+1)·P+1.
- `done` is high in cycle D+N·P+1, coincident with the last `out_valid`. `busy` is low that cycle.
- A new `run` is accepted in cycle D+N·P+1 or later. Back-to-back jobs are legal.
- Degenerate job (P=0 or N=0): `busy` is never high and `done` is high in cycle 1.
- Reset values: `out0`=0, `out_valid`=0, `busy`=0, `done`=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the state encoding localparams (IDLE/WAIT/ACCUM, 2 bits);
  - a width helper constant for the counter widths.
- One natural sub-module, `load_down_counter`:
  - parameterised width, load/enable/zero flag;
  - instantiated three times (delay, period, iteration counters).
- Accumulator, output register and FSM live in the top module.

## Test plan
- Basic job: D=0, P=4, N=1, `in0`=1,2,3,4 in cycles 1–4 -> `out0`=10, `out_valid` and `done` in cycle 5.
- Delay alignment: D=3, P=2, N=3, `in0`=cycle index -> sums 9, 13, 17 in cycles 6, 8, 10. `done` in cycle 10, `busy` high in cycles 1–9.
- Overflow: DATA_W=32, P=2, samples 0xFFFF_FFFF and 0x2 -> `out0`=0x1.
- Degenerate and ignored inputs:
  - P=0 -> `done` in cycle 1, `out0` held, no `busy`.
  - `run` and config changes mid-job -> no effect on sums or timing.
- Reset mid-job: drive `rst`=0 during ACCUM of window 1 -> outputs 0 immediately, no `done`. A fresh `run` after release completes normally.
- Back-to-back: second `run` in the `done` cycle -> second job starts with its cycle 0 at that cycle, and its results match an isolated run.
